// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - FWFT receive byte buffer behind uart_rx
// Counted circular buffer with almost-full threshold and sticky overrun flag.
module uart_rx_fifo #(
  parameter int D_W    = 8,
  parameter int ADDR_W = 4,
  parameter int AF_LVL = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [D_W-1:0]    wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [D_W-1:0]    rd_data,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overrun,
  input  logic              clr_overrun
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LVL);

  logic [D_W-1:0]    mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              pop;
  logic              push;
  logic              drop;

  assign empty       = (count == '0);
  assign full        = (count == DEPTH_C);
  assign almost_full = (count >= AF_C);
  assign rd_valid    = !empty;
  assign rd_data     = mem[rd_ptr];

  // A full buffer still accepts a byte when the head leaves in the same cycle.
  assign pop  = rd_valid && rd_ready;
  assign push = wr_en && (!full || pop);
  assign drop = wr_en && full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Set takes priority over a coincident clear so a fresh drop is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

endmodule
